load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Executes the MEMORY phase of LOAD/STORE instructions for the multi-cycle core.
- Accepts a one-cycle start pulse when the control FSM enters MEMORY.
- Runs one word-aligned req/ready transaction on the data-memory bus, aligns and extends load data, and pulses done.
- done drives the state machine's state_finish for the MEMORY state; the FSM does not advance until done.

Parameters:
- ADDR_WIDTH, 32, byte-address width of addr and mem_addr.
- TIMEOUT_CYCLES, 255, maximum cycles a request waits for mem_ready before aborting; must be ≥1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  one-cycle pulse: begin access; honoured only in IDLE.
- is_store  input  1  1 = store, 0 = load; sampled with start.
- funct3  input  3  access size and sign: LB=000, LH=001, LW=010, LBU=100, LHU=101, SB=000, SH=001, SW=010.
- addr  input  ADDR_WIDTH  effective byte address; sampled with start.
- store_data  input  32  rs2 value; sampled with start.
- mem_req  output  1  bus request.
- mem_we  output  1  1 = write.
- mem_addr  output  ADDR_WIDTH  word address {addr[ADDR_WIDTH-1:2],2'b00}.
- mem_wstrb  output  4  byte-lane write enables; 0 for loads.
- mem_wdata  output  32  lane-replicated store data.
- mem_ready  input  1  slave completes the transfer in the cycle it is sampled high with mem_req.
- mem_rdata  input  32  read word; valid when mem_ready is high.
- done  output  1  one-cycle completion pulse to state_finish.
- load_data  output  32  aligned and extended load result; held until the next load completes.
- misalign  output  1  sticky error flag for the last access: misaligned or illegal funct3; cleared by start.
- bus_err  output  1  sticky error flag for the last access: timeout; cleared by start.

Behaviour:
- Reset (async, any state, including mid-transaction):
  - state IDLE; all outputs 0 immediately.
  - Timeout counter cleared.
- FSM states: IDLE, REQ, RESP.
  - IDLE --start--> REQ when the access is legal.
  - IDLE --start--> RESP when misaligned/illegal: no bus activity, misalign=1.
  - REQ --mem_ready--> RESP.
  - REQ --timeout--> RESP with bus_err=1.
  - RESP --> IDLE unconditionally.
  - done=1 only in RESP.
- Start handling:
  - start sampled only in IDLE; start in REQ/RESP is ignored.
  - start latches is_store, funct3, addr and store_data.
  - start clears misalign and bus_err.
- Legality checks:
  - Halfword (funct3[1:0]=01) requires addr[0]=0.
  - Word (10) requires addr[1:0]=00.
  - funct3[1:0]=11 is illegal.
  - A store with funct3[2]=1 is illegal.
- REQ phase:
  - mem_req=1, with mem_we, mem_addr, mem_wstrb and mem_wdata registered and stable until ready.
  - mem_req drops in the cycle after mem_ready is sampled.
- Latency:
  - start at cycle N, mem_req high at N+1.
  - Ready at N+1 gives done at N+2.
  - Each extra wait cycle adds 1.
  - Misaligned/illegal access: done at N+1.
- Timeout:
  - Counter increments on each REQ cycle without mem_ready.
  - When it reaches TIMEOUT_CYCLES, go to RESP: mem_req=0 next cycle, bus_err=1, load_data unchanged.
  - mem_ready in the same cycle as the limit: ready wins, no error.
- Store lanes:
  - SB: wdata={4{sd[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{sd[15:0]}}, wstrb=addr[1]?1100:0011.
  - SW: wdata=sd, wstrb=1111.
- Load result:
  - Lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW is the full word.
  - load_data is registered on the ready cycle, so it is valid with done.
  - load_data is unchanged on stores and on errors.

Decomposition:
- Shared package _riscv_defines gets:
  - funct3 constants F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - lsu_state_t enum {LSU_IDLE, LSU_REQ, LSU_RESP}.
- One sub-module: lsu_align, purely combinational.
  - Inputs: funct3, addr[1:0], store_data, mem_rdata.
  - Outputs: wstrb, wdata, extended load value, legal.
- load_store_unit holds the FSM, the latches and the timeout counter.

Test Plan:
- LW addr=0x100, ready same cycle as req, rdata=0xDEADBEEF → mem_addr=0x100, done at N+2, load_data=0xDEADBEEF, no errors.
- LB addr=0x103, rdata=0x80123456 → load_data=0xFFFFFF80; LBU same → 0x00000080; LH addr=0x102 → 0xFFFF8012.
- SB addr=0x201, sd=0x000000A5 → mem_we=1, wstrb=0010, wdata=0xA5A5A5A5, mem_addr=0x200; SH addr=0x202, sd=0x1234 → wstrb=1100, wdata=0x12341234.
- LW addr=0x101, then SH addr=0x103 → no mem_req, done at N+1, misalign=1; next legal start clears misalign.
- TIMEOUT_CYCLES=4, mem_ready held low → mem_req high 4 cycles then low, done with bus_err=1; a second start mid-REQ is ignored.
- Reset asserted while mem_req=1 in wait state → mem_req, done and flags go to 0 immediately; after release, start gives a normal transaction.

Source files
------------

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the load/store unit: funct3 access codes and FSM state type.
package load_store_unit_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        LSU_IDLE,
        LSU_REQ,
        LSU_RESP
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: store byte strobes and replication, load lane select and extension, size/alignment legality.
module lsu_align
    import load_store_unit_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr_lo,
    input  logic [31:0] store_data,
    input  logic [31:0] mem_rdata,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output logic [31:0] load_ext,
    output logic        legal
);

    logic signed [7:0]  byte_s;
    logic signed [15:0] half_s;

    always_comb begin
        wstrb    = 4'b0000;
        wdata    = store_data;
        load_ext = 32'h0;
        legal    = 1'b0;
        byte_s   = mem_rdata[8*addr_lo +: 8];
        half_s   = addr_lo[1] ? mem_rdata[31:16] : mem_rdata[15:0];

        // funct3[2] selects zero-extension; it never changes the lane choice
        case (funct3[1:0])
            2'b00: begin
                legal    = 1'b1;
                wstrb    = 4'b0001 << addr_lo;
                wdata    = {4{store_data[7:0]}};
                load_ext = funct3[2] ? {24'h0, byte_s} : 32'(byte_s);
            end
            2'b01: begin
                legal    = ~addr_lo[0];
                wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
                wdata    = {2{store_data[15:0]}};
                load_ext = funct3[2] ? {16'h0, half_s} : 32'(half_s);
            end
            2'b10: begin
                legal    = (addr_lo == 2'b00);
                wstrb    = 4'b1111;
                wdata    = store_data;
                load_ext = mem_rdata;
            end
            default: begin
                legal = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// MEMORY-phase load/store engine: one word-aligned req/ready bus transfer per start, with timeout and error flags.
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  is_store,
    input  logic [2:0]            funct3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [31:0]           store_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [3:0]            mem_wstrb,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_ready,
    input  logic [31:0]           mem_rdata,
    output logic                  done,
    output logic [31:0]           load_data,
    output logic                  misalign,
    output logic                  bus_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    lsu_state_t       state;
    logic [2:0]       funct3_q;
    logic [1:0]       addr_lo_q;
    logic             is_store_q;
    logic [CNT_W-1:0] tmo_cnt;

    logic [2:0]  al_funct3;
    logic [1:0]  al_addr_lo;
    logic [3:0]  al_wstrb;
    logic [31:0] al_wdata;
    logic [31:0] al_load;
    logic        al_legal;
    logic        access_legal;

    // In IDLE the aligner sees the live request; afterwards it sees the latched one
    assign al_funct3    = (state == LSU_IDLE) ? funct3 : funct3_q;
    assign al_addr_lo   = (state == LSU_IDLE) ? addr[1:0] : addr_lo_q;
    assign access_legal = al_legal & ~(is_store & funct3[2]);

    lsu_align u_align (
        .funct3     (al_funct3),
        .addr_lo    (al_addr_lo),
        .store_data (store_data),
        .mem_rdata  (mem_rdata),
        .wstrb      (al_wstrb),
        .wdata      (al_wdata),
        .load_ext   (al_load),
        .legal      (al_legal)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= LSU_IDLE;
            funct3_q   <= 3'b000;
            addr_lo_q  <= 2'b00;
            is_store_q <= 1'b0;
            tmo_cnt    <= '0;
            mem_req    <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wstrb  <= 4'b0000;
            mem_wdata  <= 32'h0;
            done       <= 1'b0;
            load_data  <= 32'h0;
            misalign   <= 1'b0;
            bus_err    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                LSU_IDLE: begin
                    if (start) begin
                        funct3_q   <= funct3;
                        addr_lo_q  <= addr[1:0];
                        is_store_q <= is_store;
                        tmo_cnt    <= '0;
                        bus_err    <= 1'b0;
                        if (access_legal) begin
                            state     <= LSU_REQ;
                            misalign  <= 1'b0;
                            mem_req   <= 1'b1;
                            mem_we    <= is_store;
                            mem_addr  <= {addr[ADDR_WIDTH-1:2], 2'b00};
                            mem_wstrb <= is_store ? al_wstrb : 4'b0000;
                            mem_wdata <= is_store ? al_wdata : 32'h0;
                        end else begin
                            state    <= LSU_RESP;
                            misalign <= 1'b1;
                            done     <= 1'b1;
                        end
                    end
                end
                LSU_REQ: begin
                    // A ready arriving on the final allowed cycle still completes normally
                    if (mem_ready) begin
                        state     <= LSU_RESP;
                        done      <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                        if (!is_store_q) begin
                            load_data <= al_load;
                        end
                    end else if (tmo_cnt == CNT_LAST) begin
                        state     <= LSU_RESP;
                        done      <= 1'b1;
                        bus_err   <= 1'b1;
                        mem_req   <= 1'b0;
                        mem_we    <= 1'b0;
                        mem_wstrb <= 4'b0000;
                    end else begin
                        tmo_cnt <= tmo_cnt + CNT_W'(1);
                    end
                end
                LSU_RESP: begin
                    state <= LSU_IDLE;
                end
                default: begin
                    state <= LSU_IDLE;
                end
            endcase
        end
    end

endmodule
